// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter.
package mmio_bus_arbiter_pkg;

  localparam int REGBUS = 32;
  localparam logic [REGBUS-1:0] ZEROWORD = '0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_e;

  // One master's request as latched at grant time.
  typedef struct packed {
    logic              we;
    logic [REGBUS-1:0] addr;
    logic [3:0]        sel;
    logic [REGBUS-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mmio_bus_arbiter_rr_pick2.sv
// Combinational two-way winner select; the round-robin pointer lives in the parent.
module rr_pick2 #(
  parameter int M0_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       grant,
  output logic       winner
);

  // Single requester wins; on a tie either master 0 (priority) or the previous loser wins.
  always_comb begin
    grant  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = (M0_PRIO != 0) ? 1'b0 : ~rr_last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master req/ack arbiter in front of a single synchronous-RAM slave bus.
// RD_LAT must lie in 1..4 (the latency counter is two bits wide).
module mmio_bus_arbiter
  import mmio_bus_arbiter_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int M0_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [REGBUS-1:0] m0_addr,
  input  logic [3:0]        m0_sel,
  input  logic [REGBUS-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [REGBUS-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [REGBUS-1:0] m1_addr,
  input  logic [3:0]        m1_sel,
  input  logic [REGBUS-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [REGBUS-1:0] m1_rdata,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [REGBUS-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [REGBUS-1:0] ram_data_o,
  input  logic [REGBUS-1:0] ram_data_i,
  output logic              owner,
  output logic              busy
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  bus_req_t          lat_q, lat_d;
  logic [REGBUS-1:0] m0_rdata_q, m0_rdata_d;
  logic [REGBUS-1:0] m1_rdata_q, m1_rdata_d;
  logic [1:0]        ack_q, ack_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;

  bus_req_t m0_bus, m1_bus;
  logic     pick_grant, pick_winner;

  assign m0_bus = '{we: m0_we, addr: m0_addr, sel: m0_sel, wdata: m0_wdata};
  assign m1_bus = '{we: m1_we, addr: m1_addr, sel: m1_sel, wdata: m1_wdata};

  rr_pick2 #(.M0_PRIO(M0_PRIO)) u_pick (
    .req     ({m1_req, m0_req}),
    .rr_last (rr_last_q),
    .grant   (pick_grant),
    .winner  (pick_winner)
  );

  // Next-state logic: grant in IDLE, count out the slave latency in XFER, one ACK cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_last_d  = rr_last_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    ack_d      = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (pick_grant) begin
          state_d   = ARB_XFER;
          owner_d   = pick_winner;
          rr_last_d = pick_winner;
          lat_d     = pick_winner ? m1_bus : m0_bus;
          cnt_d     = lat_d.we ? 2'd0 : CNT_INIT;
        end
      end
      ARB_XFER: begin
        if (cnt_q == 2'd0) begin
          state_d        = ARB_ACK;
          ack_d[owner_q] = 1'b1;
          if (!lat_q.we) begin
            if (owner_q) m1_rdata_d = ram_data_i;
            else         m0_rdata_d = ram_data_i;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ARB_ACK:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    // Slave strobes and busy are registered from the upcoming state.
    ce_d   = (state_d == ARB_XFER);
    we_d   = ce_d & lat_d.we;
    busy_d = (state_d != ARB_IDLE);
  end

  // State and registered outputs; reset aborts any transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= 2'd0;
      rr_last_q  <= 1'b1;
      owner_q    <= 1'b0;
      lat_q      <= '0;
      m0_rdata_q <= ZEROWORD;
      m1_rdata_q <= ZEROWORD;
      ack_q      <= 2'b00;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_last_q  <= rr_last_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      ack_q      <= ack_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
    end
  end

  assign m0_ack     = ack_q[0];
  assign m1_ack     = ack_q[1];
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign ram_ce_o   = ce_q;
  assign ram_we_o   = we_q;
  assign ram_addr_o = lat_q.addr;
  assign ram_sel_o  = lat_q.sel;
  assign ram_data_o = lat_q.wdata;
  assign owner      = owner_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: three instances (RD_LAT=1 round-robin, RD_LAT=1 m0-priority,
// RD_LAT=3 round-robin) checked every cycle against a transaction-timeline model.
module tb_mmio_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0][1:0]       req, we;
  logic [2:0][1:0][31:0] addr, wdata;
  logic [2:0][1:0][3:0]  sel;
  logic [2:0][31:0]      sdin;
  logic [2:0]            m0_ack, m1_ack, ce, rwe, owner, busy;
  logic [2:0][31:0]      m0_rd, m1_rd, raddr, rdat;
  logic [2:0][3:0]       rsel;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mmio_bus_arbiter #(.RD_LAT(gi == 2 ? 3 : 1), .M0_PRIO(gi == 1 ? 1 : 0)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req[gi][0]), .m0_we(we[gi][0]), .m0_addr(addr[gi][0]), .m0_sel(sel[gi][0]),
      .m0_wdata(wdata[gi][0]), .m0_ack(m0_ack[gi]), .m0_rdata(m0_rd[gi]),
      .m1_req(req[gi][1]), .m1_we(we[gi][1]), .m1_addr(addr[gi][1]), .m1_sel(sel[gi][1]),
      .m1_wdata(wdata[gi][1]), .m1_ack(m1_ack[gi]), .m1_rdata(m1_rd[gi]),
      .ram_ce_o(ce[gi]), .ram_we_o(rwe[gi]), .ram_addr_o(raddr[gi]), .ram_sel_o(rsel[gi]),
      .ram_data_o(rdat[gi]), .ram_data_i(sdin[gi]), .owner(owner[gi]), .busy(busy[gi])
    );
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic int cfg_lat(input int i);
    return (i == 2) ? 3 : 1;
  endfunction
  function automatic bit cfg_prio(input int i);
    return (i == 1);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%08h expected 0x%08h", nm, i, act, exp);
    end
  endtask

  // ---------------- reference model: each transaction is a time window ----------------
  int          edge_n;
  int          next_s[3], grant_e[3], ack_e[3];
  bit          have[3], rr[3], own[3], lwe[3];
  logic [31:0] laddr[3], ldata[3];
  logic [3:0]  lsel[3];
  logic [31:0] mrd[3][2];

  function automatic bit model_ack(input int i, input int m);
    return have[i] && (edge_n == ack_e[i]) && (int'(own[i]) == m);
  endfunction

  task automatic model_edge(input int i);
    bit w;
    if (rst) begin
      have[i] = 0; next_s[i] = edge_n + 1; rr[i] = 1; own[i] = 0; lwe[i] = 0;
      laddr[i] = 0; ldata[i] = 0; lsel[i] = 0; mrd[i][0] = 0; mrd[i][1] = 0;
    end else begin
      if (have[i] && edge_n == ack_e[i] && !lwe[i]) mrd[i][own[i]] = sdin[i];
      if (edge_n >= next_s[i] && req[i] != 2'b00) begin
        if (req[i] == 2'b01)      w = 0;
        else if (req[i] == 2'b10) w = 1;
        else                      w = cfg_prio(i) ? 1'b0 : !rr[i];
        rr[i] = w; own[i] = w; lwe[i] = we[i][w];
        laddr[i] = addr[i][w]; lsel[i] = sel[i][w]; ldata[i] = wdata[i][w];
        grant_e[i] = edge_n;
        ack_e[i] = edge_n + (lwe[i] ? 1 : cfg_lat(i));
        next_s[i] = ack_e[i] + 2;
        have[i] = 1;
      end
    end
  endtask

  initial begin
    edge_n = 0;
    for (int i = 0; i < 3; i++) begin
      have[i] = 0; next_s[i] = 0; grant_e[i] = 0; ack_e[i] = 0;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 3; i++) model_edge(i);
    end
  end

  task automatic check_all();
    bit x;
    for (int i = 0; i < 3; i++) begin
      x = have[i] && edge_n >= grant_e[i] && edge_n < ack_e[i];
      chk("m0_ack", i, 32'(m0_ack[i]), 32'(model_ack(i, 0)));
      chk("m1_ack", i, 32'(m1_ack[i]), 32'(model_ack(i, 1)));
      chk("m0_rdata", i, m0_rd[i], mrd[i][0]);
      chk("m1_rdata", i, m1_rd[i], mrd[i][1]);
      chk("ram_ce", i, 32'(ce[i]), 32'(x));
      chk("ram_we", i, 32'(rwe[i]), 32'(x && lwe[i]));
      chk("ram_addr", i, raddr[i], laddr[i]);
      chk("ram_sel", i, 32'(rsel[i]), 32'(lsel[i]));
      chk("ram_data", i, rdat[i], ldata[i]);
      chk("owner", i, 32'(owner[i]), 32'(own[i]));
      chk("busy", i, 32'(busy[i]), 32'(have[i] && edge_n >= grant_e[i] && edge_n <= ack_e[i]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) check_all();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          inst;
    int          m;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[6];

  function automatic logic get_ack(input int i, input int m);
    return (m == 1) ? m1_ack[i] : m0_ack[i];
  endfunction
  function automatic logic [31:0] get_rd(input int i, input int m);
    return (m == 1) ? m1_rd[i] : m0_rd[i];
  endfunction

  initial begin
    int got, cnt, last, i, m;
    int own_seq[6];
    rst = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; sel = '0; sdin = '0;

    vecs[0] = '{0, 0, 1'b0, 32'h10000004, 4'hF, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF};
    vecs[1] = '{0, 1, 1'b1, 32'h00012000, 4'h1, 32'h000000AA, 32'h55555555, 1, 32'h00000000};
    vecs[2] = '{2, 0, 1'b0, 32'h10000100, 4'hF, 32'h0,        32'h12345678, 3, 32'h12345678};
    vecs[3] = '{2, 1, 1'b1, 32'h00020000, 4'hC, 32'hABCD0000, 32'h99999999, 1, 32'h00000000};
    vecs[4] = '{1, 1, 1'b0, 32'h00030008, 4'h3, 32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D};
    vecs[5] = '{2, 1, 1'b0, 32'h0004000C, 4'hF, 32'h0,        32'hA5A5C3C3, 3, 32'hA5A5C3C3};

    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", k, 32'(busy[k]), 32'h0);
      chk("reset_m0_rdata", k, m0_rd[k], 32'h0);
    end

    for (int v = 0; v < 6; v++) begin
      i = vecs[v].inst; m = vecs[v].m;
      repeat (2) step();
      sdin[i] = vecs[v].sdata; we[i][m] = vecs[v].we; addr[i][m] = vecs[v].addr;
      sel[i][m] = vecs[v].sel; wdata[i][m] = vecs[v].wdata; req[i][m] = 1'b1;
      got = -1;
      for (int c = 0; c < 8; c++) begin
        step();
        if (c == 0) begin
          chk("vec_ce", i, 32'(ce[i]), 32'h1);
          chk("vec_we", i, 32'(rwe[i]), 32'(vecs[v].we));
          chk("vec_addr", i, raddr[i], vecs[v].addr);
          chk("vec_sel", i, 32'(rsel[i]), 32'(vecs[v].sel));
          chk("vec_wdata", i, rdat[i], vecs[v].wdata);
        end
        chk("vec_other_ack", i, 32'(get_ack(i, 1 - m)), 32'h0);
        if (get_ack(i, m)) begin got = c; break; end
      end
      req[i][m] = 1'b0;
      chk("vec_latency", i, 32'(got), 32'(vecs[v].lat));
      chk("vec_rdata", i, get_rd(i, m), vecs[v].rdata);
    end

    // Round-robin alternation on instance 0 with both masters reading continuously.
    repeat (2) step();
    we[0] = 2'b00; addr[0][0] = 32'h100; addr[0][1] = 32'h200; req[0] = 2'b11;
    cnt = 0; last = -1;
    for (int c = 0; c < 40 && cnt < 6; c++) begin
      step();
      if (m0_ack[0] || m1_ack[0]) begin
        own_seq[cnt] = m1_ack[0] ? 1 : 0;
        chk("rr_owner", 0, 32'(own_seq[cnt]), 32'(cnt % 2));
        if (last >= 0) chk("rr_spacing", 0, 32'(c - last), 32'd3);
        last = c; cnt++;
      end
    end
    req[0] = 2'b00;
    chk("rr_ack_count", 0, 32'(cnt), 32'd6);

    // Master-0 priority on instance 1: m1 starves until m0 lets go.
    repeat (2) step();
    we[1] = 2'b00; req[1] = 2'b11; cnt = 0;
    for (int c = 0; c < 30 && cnt < 4; c++) begin
      step();
      chk("prio_m1_starved", 1, 32'(m1_ack[1]), 32'h0);
      if (m0_ack[1]) cnt++;
    end
    chk("prio_m0_acks", 1, 32'(cnt), 32'd4);
    req[1][0] = 1'b0;
    got = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (m1_ack[1]) begin got = c; break; end
    end
    req[1][1] = 1'b0;
    chk("prio_m1_granted_after_drop", 1, 32'(got >= 0), 32'h1);

    // Reset in the second XFER cycle of an RD_LAT=3 read, then retry.
    repeat (2) step();
    we[2][0] = 1'b0; addr[2][0] = 32'h10000040; sdin[2] = 32'h11112222; req[2][0] = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_busy", 2, 32'(busy[2]), 32'h0);
    chk("rst_ce", 2, 32'(ce[2]), 32'h0);
    chk("rst_ack", 2, 32'(m0_ack[2]), 32'h0);
    chk("rst_m0_rdata", 2, m0_rd[2], 32'h0);
    chk("rst_addr", 2, raddr[2], 32'h0);
    rst = 1'b0;
    got = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (m0_ack[2]) begin got = c; break; end
    end
    req[2][0] = 1'b0;
    chk("retry_latency", 2, 32'(got), 32'd3);
    chk("retry_rdata", 2, m0_rd[2], 32'h11112222);

    // m1 drops its request mid-XFER: transaction still completes exactly once.
    repeat (2) step();
    we[2][1] = 1'b0; addr[2][1] = 32'h00000F00; sdin[2] = 32'h0BADF00D; req[2][1] = 1'b1;
    step();
    req[2][1] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (m1_ack[2]) cnt++;
    end
    chk("drop_ack_count", 2, 32'(cnt), 32'd1);
    chk("drop_rdata", 2, m1_rd[2], 32'h0BADF00D);
    chk("drop_idle", 2, 32'(busy[2]), 32'h0);

    // Randomized traffic with occasional resets and protocol-violating drops.
    for (int c = 0; c < 1500; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
        sdin[k] = $urandom;
        for (int n = 0; n < 2; n++) begin
          if (req[k][n]) begin
            if (model_ack(k, n) || $urandom_range(0, 63) == 0) req[k][n] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            req[k][n] = 1'b1;
            we[k][n] = 1'($urandom_range(0, 1));
            addr[k][n] = $urandom;
            sel[k][n] = 4'($urandom);
            wdata[k][n] = $urandom;
          end
        end
      end
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
